// File: rtl/ads_ddr_capture.sv
// ads_ddr_capture
// Multi-channel LVDS DDR capture for ADS42xx-class ADCs. Each channel has LANES
// differential lanes, and each lane carries two bits per AD_CLK_IN period.
// The block trains a per-channel half-cycle word alignment against a fixed
// test pattern and reports lock/fail status. It then delivers decimated,
// optionally MSB-inverted samples with a one-cycle valid strobe.
//
// Ports
//   AD_CLK_IN    in   1                 ADC data clock, the only clock
//   RESET        in   1                 async active-low reset
//   AD_DIN_P/N   in   CHANNELS*LANES    differential lane inputs, ch c = [c*LANES +: LANES]
//   TRAIN_START  in   1                 one-cycle pulse, (re)start alignment
//   FORMAT_OB    in   1                 1: invert sample MSB (offset binary -> two's complement)
//   DECIM        in   8                 keep 1 of DECIM+1 samples
//   AD_DATA      out  CHANNELS*DATA_W   aligned samples, ch c = [c*DATA_W +: DATA_W]
//   AD_VALID     out  1                 AD_DATA carries a kept sample this cycle
//   LOCKED       out  1                 all channels aligned
//   TRAIN_FAIL   out  1                 alignment failed, sticky until TRAIN_START/reset
//   EDGE_SEL     out  CHANNELS          per-channel edge select in use
module ads_ddr_capture #(
    parameter int                 CHANNELS      = 2,
    parameter int                 LANES         = 6,
    parameter logic [2*LANES-1:0] TRAIN_PATTERN = 12'b1010_0101_1100,
    parameter int                 LOCK_COUNT    = 64,
    parameter int                 SETTLE_CYC    = 4
) (
    input  logic                        AD_CLK_IN,
    input  logic                        RESET,
    input  logic [CHANNELS*LANES-1:0]   AD_DIN_P,
    input  logic [CHANNELS*LANES-1:0]   AD_DIN_N,
    input  logic                        TRAIN_START,
    input  logic                        FORMAT_OB,
    input  logic [7:0]                  DECIM,
    output logic [CHANNELS*2*LANES-1:0] AD_DATA,
    output logic                        AD_VALID,
    output logic                        LOCKED,
    output logic                        TRAIN_FAIL,
    output logic [CHANNELS-1:0]         EDGE_SEL
);

    localparam int DATA_W  = 2 * LANES;
    localparam int NLANE   = CHANNELS * LANES;
    localparam int CNT_MAX = (LOCK_COUNT > SETTLE_CYC) ? LOCK_COUNT : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_CHECK  = 3'd2,
        S_LOCKED = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    // Differential receiver: a lane reads 1 when P is high and N is low.
    logic [NLANE-1:0] din_s;
    assign din_s = AD_DIN_P & ~AD_DIN_N;

    // IDDR (same-edge pipelined) and alignment datapath registers
    logic [NLANE-1:0] rise_cap_q, rise_cap_d;
    logic [NLANE-1:0] fall_cap_q, fall_cap_d;
    logic [NLANE-1:0] q1_q, q1_d, q2_q, q2_d, q2_prev_q, q2_prev_d;
    logic [CHANNELS*DATA_W-1:0] w_q, w_d, ad_data_q, ad_data_d;

    // Control registers
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                attempt_q, attempt_d;
    logic [CHANNELS-1:0] flags_q, flags_d, flags_all_s, mismatch_s;
    logic [CHANNELS-1:0] edge_sel_q, edge_sel_d;
    logic                locked_q, locked_d, fail_q, fail_d;
    logic [7:0]          dec_cnt_q, dec_cnt_d, decim_lat_q, decim_lat_d;
    logic                valid_q, valid_d;

    // Datapath next-state: IDDR pipeline, word build, output formatting
    always_comb begin
        rise_cap_d = din_s;
        fall_cap_d = din_s;
        q1_d       = rise_cap_q;
        q2_d       = fall_cap_q;
        q2_prev_d  = q2_q;
        w_d        = {(CHANNELS*DATA_W){1'b0}};
        ad_data_d  = {(CHANNELS*DATA_W){1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < LANES; i++) begin
                // Edge select 1 pairs the previous falling bit with the current rising bit.
                if (edge_sel_q[c]) begin
                    w_d[c*DATA_W + 2*i]     = q2_prev_q[c*LANES + i];
                    w_d[c*DATA_W + 2*i + 1] = q1_q[c*LANES + i];
                end else begin
                    w_d[c*DATA_W + 2*i]     = q1_q[c*LANES + i];
                    w_d[c*DATA_W + 2*i + 1] = q2_q[c*LANES + i];
                end
            end
            ad_data_d[c*DATA_W +: DATA_W] = w_q[c*DATA_W +: DATA_W]
                                          ^ {FORMAT_OB, {(DATA_W-1){1'b0}}};
            mismatch_s[c] = (w_q[c*DATA_W +: DATA_W] != TRAIN_PATTERN);
        end
    end

    // Training FSM next-state and alignment decisions
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        attempt_d   = attempt_q;
        flags_d     = flags_q;
        edge_sel_d  = edge_sel_q;
        flags_all_s = flags_q | mismatch_s;
        if (TRAIN_START) begin
            state_d    = S_SETTLE;
            cnt_d      = {CNT_W{1'b0}};
            attempt_d  = 1'b0;
            flags_d    = {CHANNELS{1'b0}};
            edge_sel_d = {CHANNELS{1'b0}};
        end else begin
            case (state_q)
                S_SETTLE: begin
                    flags_d = {CHANNELS{1'b0}};
                    if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_CHECK: begin
                    flags_d = flags_all_s;
                    if (cnt_q == CNT_W'(LOCK_COUNT - 1)) begin
                        cnt_d = {CNT_W{1'b0}};
                        if (flags_all_s == {CHANNELS{1'b0}}) begin
                            state_d = S_LOCKED;
                        end else if (!attempt_q) begin
                            // Second attempt flips only the channels that failed.
                            edge_sel_d = edge_sel_q ^ flags_all_s;
                            attempt_d  = 1'b1;
                            state_d    = S_SETTLE;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_IDLE, S_LOCKED, S_FAIL: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        locked_d = (state_d == S_LOCKED);
        fail_d   = (state_d == S_FAIL);
    end

    // Decimation counter and valid strobe, active only while locked
    always_comb begin
        dec_cnt_d   = 8'd0;
        decim_lat_d = decim_lat_q;
        valid_d     = 1'b0;
        if ((state_d == S_LOCKED) && (state_q != S_LOCKED)) begin
            decim_lat_d = DECIM;
            valid_d     = 1'b1;
        end else if ((state_d == S_LOCKED) && (state_q == S_LOCKED)) begin
            // DECIM is sampled at each wrap; a new DECIM below the count forces a wrap.
            if ((dec_cnt_q >= decim_lat_q) || (dec_cnt_q > DECIM)) begin
                decim_lat_d = DECIM;
                valid_d     = 1'b1;
            end else begin
                dec_cnt_d = dec_cnt_q + 8'd1;
            end
        end else begin
            dec_cnt_d = 8'd0;
        end
    end

    // Falling-edge half of the IDDR capture
    always_ff @(negedge AD_CLK_IN or negedge RESET) begin
        if (!RESET) begin
            fall_cap_q <= {NLANE{1'b0}};
        end else begin
            fall_cap_q <= fall_cap_d;
        end
    end

    // Rising-edge registers: datapath, FSM state and status outputs
    always_ff @(posedge AD_CLK_IN or negedge RESET) begin
        if (!RESET) begin
            rise_cap_q  <= {NLANE{1'b0}};
            q1_q        <= {NLANE{1'b0}};
            q2_q        <= {NLANE{1'b0}};
            q2_prev_q   <= {NLANE{1'b0}};
            w_q         <= {(CHANNELS*DATA_W){1'b0}};
            ad_data_q   <= {(CHANNELS*DATA_W){1'b0}};
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            attempt_q   <= 1'b0;
            flags_q     <= {CHANNELS{1'b0}};
            edge_sel_q  <= {CHANNELS{1'b0}};
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            dec_cnt_q   <= 8'd0;
            decim_lat_q <= 8'd0;
            valid_q     <= 1'b0;
        end else begin
            rise_cap_q  <= rise_cap_d;
            q1_q        <= q1_d;
            q2_q        <= q2_d;
            q2_prev_q   <= q2_prev_d;
            w_q         <= w_d;
            ad_data_q   <= ad_data_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            attempt_q   <= attempt_d;
            flags_q     <= flags_d;
            edge_sel_q  <= edge_sel_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            dec_cnt_q   <= dec_cnt_d;
            decim_lat_q <= decim_lat_d;
            valid_q     <= valid_d;
        end
    end

    assign AD_DATA    = ad_data_q;
    assign AD_VALID   = valid_q;
    assign LOCKED     = locked_q;
    assign TRAIN_FAIL = fail_q;
    assign EDGE_SEL   = edge_sel_q;

endmodule

// File: tb/tb_ads_ddr_capture.sv
// Directed testbench for ads_ddr_capture (2 channels x 6 lanes).
// A driver serialises per-channel 12-bit words onto the DDR lanes: the rising
// slot carries bit 2i and the falling slot carries bit 2i+1. A "late" channel
// swaps the two slots, so it presents a half-cycle-shifted constant pattern.
// A word set at sample k appears on AD_DATA at sample k+4.
module tb_ads_ddr_capture;

    localparam logic [11:0] PAT = 12'b1010_0101_1100;
    localparam int WIN1 = 4 + 64 + 1;   // first window decision seen
    localparam int WIN2 = WIN1 + 4 + 64; // second window decision seen

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] din_p;
    logic [11:0] din_n;
    logic        train_start;
    logic        format_ob;
    logic [7:0]  decim;
    logic [23:0] ad_data;
    logic        ad_valid;
    logic        locked;
    logic        train_fail;
    logic [1:0]  edge_sel;

    logic [11:0] tx_word [0:1];
    logic [11:0] cur     [0:1];
    logic [1:0]  late;
    logic [11:0] hist0 [0:4095];
    logic [11:0] hist1 [0:4095];

    int checks = 0;
    int errors = 0;

    assign din_n = ~din_p;

    ads_ddr_capture dut (
        .AD_CLK_IN   (clk),
        .RESET       (rst_n),
        .AD_DIN_P    (din_p),
        .AD_DIN_N    (din_n),
        .TRAIN_START (train_start),
        .FORMAT_OB   (format_ob),
        .DECIM       (decim),
        .AD_DATA     (ad_data),
        .AD_VALID    (ad_valid),
        .LOCKED      (locked),
        .TRAIN_FAIL  (train_fail),
        .EDGE_SEL    (edge_sel)
    );

    always #5 clk = ~clk;

    // Lane serialiser: rising-slot bits after each negedge, falling-slot bits after each posedge
    always begin
        @(negedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            cur[c] = tx_word[c];
            for (int i = 0; i < 6; i++)
                din_p[c*6+i] = late[c] ? cur[c][2*i+1] : cur[c][2*i];
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 6; i++)
                din_p[c*6+i] = late[c] ? cur[c][2*i] : cur[c][2*i+1];
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Pulse TRAIN_START and wait for LOCKED (or TRAIN_FAIL); n = samples until seen
    task automatic train(input bit want_fail, input bit rand_ch0, output int n,
                         output logic [1:0] es_mid, output logic lk_mid);
        train_start = 1'b1;
        if (rand_ch0) tx_word[0] = 12'($urandom);
        step();
        train_start = 1'b0;
        n = 1;
        es_mid = 2'b00;
        lk_mid = 1'b0;
        while (!(want_fail ? train_fail : locked) && n < 400) begin
            if (rand_ch0) tx_word[0] = 12'($urandom);
            step();
            n++;
            if (n == WIN1) begin
                es_mid = edge_sel;
                lk_mid = locked;
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) step();
        checks += 5;
        if (ad_data !== 24'h0) begin errors++; $display("FAIL reset_data got %h exp 000000", ad_data); end
        if (ad_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ad_valid); end
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
        if (train_fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b exp 0", train_fail); end
        if (edge_sel !== 2'b00) begin errors++; $display("FAIL reset_edge got %b exp 00", edge_sel); end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step();
        checks += 2;
        if (ad_data !== {PAT, PAT}) begin errors++; $display("FAIL idle_capture got %h exp %h", ad_data, {PAT, PAT}); end
        if (locked !== 1'b0) begin errors++; $display("FAIL idle_locked got %b exp 0", locked); end
    endtask

    task automatic test_reset_mid_check();
        bit glitch;
        train_start = 1'b1;
        step();
        train_start = 1'b0;
        for (int k = 0; k < 20; k++) step();
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (ad_data !== 24'h0) begin errors++; $display("FAIL midrst_data got %h exp 000000", ad_data); end
        if (locked !== 1'b0 || ad_valid !== 1'b0 || train_fail !== 1'b0) begin
            errors++; $display("FAIL midrst_status got %b%b%b exp 000", locked, ad_valid, train_fail);
        end
        if (edge_sel !== 2'b00) begin errors++; $display("FAIL midrst_edge got %b exp 00", edge_sel); end
        step();
        step();
        rst_n = 1'b1;
        glitch = 1'b0;
        for (int k = 0; k < 150; k++) begin
            step();
            if (locked !== 1'b0 || ad_valid !== 1'b0) glitch = 1'b1;
        end
        checks++;
        if (glitch !== 1'b0) begin errors++; $display("FAIL midrst_no_lock got %b exp 0", glitch); end
    endtask

    task automatic test_aligned_lock();
        int n;
        logic [1:0] es;
        logic lk;
        train(1'b0, 1'b0, n, es, lk);
        checks += 3;
        if (n !== WIN1) begin errors++; $display("FAIL aligned_lock_time got %0d exp %0d", n, WIN1); end
        if (edge_sel !== 2'b00) begin errors++; $display("FAIL aligned_edge got %b exp 00", edge_sel); end
        if (ad_data !== {PAT, PAT}) begin errors++; $display("FAIL aligned_data got %h exp %h", ad_data, {PAT, PAT}); end
    endtask

    task automatic test_late_ch1();
        int n;
        logic [1:0] es;
        logic lk;
        late = 2'b10;
        for (int k = 0; k < 4; k++) step();
        train(1'b0, 1'b0, n, es, lk);
        checks += 5;
        if (es !== 2'b10) begin errors++; $display("FAIL late_first_edge got %b exp 10", es); end
        if (lk !== 1'b0) begin errors++; $display("FAIL late_first_locked got %b exp 0", lk); end
        if (n !== WIN2) begin errors++; $display("FAIL late_lock_time got %0d exp %0d", n, WIN2); end
        if (edge_sel !== 2'b10) begin errors++; $display("FAIL late_edge got %b exp 10", edge_sel); end
        if (ad_data !== {PAT, PAT}) begin errors++; $display("FAIL late_data got %h exp %h", ad_data, {PAT, PAT}); end
        late = 2'b00;
    endtask

    task automatic test_train_fail();
        int n;
        logic [1:0] es;
        logic lk;
        train(1'b1, 1'b1, n, es, lk);
        tx_word[0] = PAT;
        checks += 4;
        if (n !== WIN2) begin errors++; $display("FAIL fail_time got %0d exp %0d", n, WIN2); end
        if (locked !== 1'b0) begin errors++; $display("FAIL fail_locked got %b exp 0", locked); end
        if (edge_sel !== 2'b01) begin errors++; $display("FAIL fail_edge got %b exp 01", edge_sel); end
        step();
        if (train_fail !== 1'b1) begin errors++; $display("FAIL fail_sticky got %b exp 1", train_fail); end
        train_start = 1'b1;
        step();
        train_start = 1'b0;
        checks += 2;
        if (train_fail !== 1'b0) begin errors++; $display("FAIL fail_clear got %b exp 0", train_fail); end
        if (edge_sel !== 2'b00) begin errors++; $display("FAIL fail_clear_edge got %b exp 00", edge_sel); end
    endtask

    task automatic test_ramp_decim();
        int n;
        logic [1:0] es;
        logic lk;
        logic [23:0] exp_data;
        logic exp_valid;
        decim = 8'd3;
        format_ob = 1'b0;
        train(1'b0, 1'b0, n, es, lk);
        checks++;
        if (ad_valid !== 1'b1) begin errors++; $display("FAIL ramp_first_valid got %b exp 1", ad_valid); end
        format_ob = 1'b1;
        for (int k = 0; k < 4096; k++) begin
            hist0[k] = 12'(k);
            hist1[k] = 12'(4095 - k);
            tx_word[0] = hist0[k];
            tx_word[1] = hist1[k];
            step();
            exp_valid = ((k + 1) % 4 == 0);
            if (k >= 3) exp_data = {hist1[k-3] ^ 12'h800, hist0[k-3] ^ 12'h800};
            else        exp_data = {PAT ^ 12'h800, PAT ^ 12'h800};
            checks += 2;
            if (ad_valid !== exp_valid) begin errors++; $display("FAIL ramp_valid k=%0d got %b exp %b", k, ad_valid, exp_valid); end
            if (ad_data !== exp_data) begin errors++; $display("FAIL ramp_data k=%0d got %h exp %h", k, ad_data, exp_data); end
        end
        format_ob = 1'b0;
        tx_word[0] = PAT;
        tx_word[1] = PAT;
        for (int k = 0; k < 5; k++) step();
    endtask

    task automatic test_decim_change();
        int n;
        logic [1:0] es;
        logic lk;
        logic exp_valid;
        decim = 8'd0;
        train(1'b0, 1'b0, n, es, lk);
        checks++;
        if (ad_valid !== 1'b1) begin errors++; $display("FAIL d0_first_valid got %b exp 1", ad_valid); end
        for (int s = 1; s <= 10; s++) begin
            step();
            checks++;
            if (ad_valid !== 1'b1) begin errors++; $display("FAIL d0_valid s=%0d got %b exp 1", s, ad_valid); end
        end
        decim = 8'd7;
        for (int t = 1; t <= 17; t++) begin
            step();
            exp_valid = (t == 1 || t == 9 || t == 17);
            checks++;
            if (ad_valid !== exp_valid) begin errors++; $display("FAIL d7_valid t=%0d got %b exp %b", t, ad_valid, exp_valid); end
        end
    endtask

    // Sequencer
    initial begin
        rst_n = 1'b0;
        din_p = 12'h000;
        train_start = 1'b0;
        format_ob = 1'b0;
        decim = 8'd0;
        late = 2'b00;
        tx_word[0] = PAT;
        tx_word[1] = PAT;
        test_reset();
        test_reset_mid_check();
        test_aligned_lock();
        test_late_ch1();
        test_train_fail();
        test_ramp_decim();
        test_decim_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
